host_uart_cmd_stream_dec: RTL

Byte-serial successor to the host UART command decoder. Consumes the UART RX byte stream directly through a valid/ready handshake and assembles frames whose length is set by the opcode. Checks frame format and reports one decoded command, or one error, per frame through a valid/ready result port. Sits between uart_rx and the command dispatch logic; adds configurable address/payload widths, a variable-length write command, inter-byte timeout and error resynchronisation.

---
 rtl/host_cmd_pkg.sv | 38 +++
 rtl/host_cmd_idle_timer.sv | 27 ++
 rtl/host_uart_cmd_stream_dec.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/host_cmd_pkg.sv
// Shared constants and types for the byte-stream host command decoder:
// opcodes, result select codes, error codes and FSM states.
package host_cmd_pkg;

    localparam logic [7:0] OP_ENC   = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h04;
    localparam logic [7:0] CMD_ID   = 8'h01;

    localparam logic [15:0] SEL_NONE    = 16'h0000;
    localparam logic [15:0] SEL_ENC_OFF = 16'h0001;
    localparam logic [15:0] SEL_ENC_ON  = 16'h0002;
    localparam logic [15:0] SEL_READ    = 16'h0003;
    localparam logic [15:0] SEL_WRITE   = 16'h0004;
    localparam logic [15:0] SEL_ERROR   = 16'hFFFF;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_OPCODE  = 3'd1,
        ERR_FILLER  = 3'd2,
        ERR_CMD_ID  = 3'd3,
        ERR_LENGTH  = 3'd4,
        ERR_TIMEOUT = 3'd5
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_RESP    = 3'd3,
        ST_FLUSH   = 3'd4
    } state_e;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_ENC) || (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/host_cmd_idle_timer.sv
// Saturating idle-cycle counter; expired_o is high during the limit_i-th
// consecutive cycle without clear_i.
module host_cmd_idle_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q >= (limit_i - CNT_W'(1)));

endmodule

// File: rtl/host_uart_cmd_stream_dec.sv
// Assembles opcode-sized frames from the UART RX byte stream and reports one
// decoded command or one error per frame.
module host_uart_cmd_stream_dec
    import host_cmd_pkg::*;
#(
    parameter int         ADDR_BYTES     = 6,
    parameter int         PAYLOAD_BYTES  = 32,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         GAP_CYCLES     = 1000,
    parameter logic [7:0] FILL_BYTE      = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [15:0]                cmd_select,
    output logic [8*ADDR_BYTES-1:0]    target_addr,
    output logic [8*PAYLOAD_BYTES-1:0] output_data,
    output logic [7:0]                 payload_len,
    output logic                       error,
    output logic [2:0]                 error_code,
    output logic                       done,
    output state_e                     dbg_state
);

    localparam int IDX_W   = $clog2(ADDR_BYTES + 2 + PAYLOAD_BYTES);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W-1:0] IDX_LAST_ADDR = IDX_W'(ADDR_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ID        = IDX_W'(ADDR_BYTES);
    localparam logic [7:0]       MAX_LEN       = 8'(PAYLOAD_BYTES);

    state_e                     state_q;
    logic [7:0]                 op_q, rem_q, len_q, payload_len_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       rx_ready_q, cmd_valid_q, error_q, done_q;
    logic [15:0]                cmd_select_q;
    logic [8*ADDR_BYTES-1:0]    target_q;
    logic [8*PAYLOAD_BYTES-1:0] data_q;
    err_code_e                  err_code_q;

    // Both ports: a beat moves on a clock edge where valid and ready are both
    // high; the result is held unchanged while cmd_valid waits for cmd_ready.
    logic xfer;
    assign xfer = rx_valid & rx_ready_q;

    logic tmr_clear, tmr_expired;
    logic [CNT_W-1:0] tmr_limit;
    assign tmr_clear = rx_valid || !(state_q inside {ST_HDR, ST_PAYLOAD, ST_FLUSH});
    assign tmr_limit = (state_q == ST_FLUSH) ? CNT_W'(GAP_CYCLES) : CNT_W'(TIMEOUT_CYCLES);

    host_cmd_idle_timer #(.CNT_W(CNT_W)) u_idle_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmr_clear),
        .limit_i   (tmr_limit),
        .expired_o (tmr_expired)
    );

    // Verdict on the byte currently offered in HDR/PAYLOAD.
    err_code_e  byte_err;
    logic       byte_last;
    logic [15:0] ok_sel;

    always_comb begin
        byte_err  = ERR_NONE;
        byte_last = 1'b0;
        ok_sel    = SEL_NONE;
        if (state_q == ST_HDR) begin
            case (op_q)
                OP_ENC: begin
                    if (idx_q < IDX_ID) begin
                        if (rx_data != FILL_BYTE) byte_err = ERR_FILLER;
                    end else if (idx_q == IDX_ID) begin
                        if (rx_data != CMD_ID) byte_err = ERR_CMD_ID;
                    end else begin
                        byte_last = 1'b1;
                        ok_sel    = (rx_data != 8'h00) ? SEL_ENC_ON : SEL_ENC_OFF;
                    end
                end
                OP_READ: begin
                    if (idx_q == IDX_LAST_ADDR) begin
                        byte_last = 1'b1;
                        ok_sel    = SEL_READ;
                    end
                end
                default: begin
                    if (idx_q == IDX_ID && (rx_data == 8'h00 || rx_data > MAX_LEN))
                        byte_err = ERR_LENGTH;
                end
            endcase
        end else if (state_q == ST_PAYLOAD && rem_q == 8'd1) begin
            byte_last = 1'b1;
            ok_sel    = SEL_WRITE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            idx_q         <= '0;
            rem_q         <= '0;
            len_q         <= '0;
            rx_ready_q    <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_select_q  <= SEL_NONE;
            target_q      <= '0;
            data_q        <= '0;
            payload_len_q <= '0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
            done_q        <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (xfer) begin
                        op_q          <= rx_data;
                        idx_q         <= '0;
                        cmd_select_q  <= SEL_NONE;
                        target_q      <= '0;
                        data_q        <= '0;
                        payload_len_q <= '0;
                        error_q       <= 1'b0;
                        err_code_q    <= ERR_NONE;
                        done_q        <= 1'b0;
                        if (is_known_op(rx_data)) begin
                            state_q <= ST_HDR;
                        end else begin
                            state_q      <= ST_RESP;
                            rx_ready_q   <= 1'b0;
                            cmd_valid_q  <= 1'b1;
                            cmd_select_q <= SEL_ERROR;
                            error_q      <= 1'b1;
                            err_code_q   <= ERR_OPCODE;
                        end
                    end
                end
                ST_HDR, ST_PAYLOAD: begin
                    if (xfer) begin
                        idx_q <= idx_q + IDX_W'(1);
                        for (int k = 0; k < ADDR_BYTES; k++) begin
                            if (state_q == ST_HDR && op_q != OP_ENC && idx_q == IDX_W'(k))
                                target_q[k*8 +: 8] <= rx_data;
                        end
                        for (int k = 0; k < PAYLOAD_BYTES; k++) begin
                            if (state_q == ST_PAYLOAD && idx_q == IDX_W'(k))
                                data_q[k*8 +: 8] <= rx_data;
                        end
                        if (state_q == ST_PAYLOAD) rem_q <= rem_q - 8'd1;
                        if (byte_err != ERR_NONE || byte_last) begin
                            state_q      <= ST_RESP;
                            rx_ready_q   <= 1'b0;
                            cmd_valid_q  <= 1'b1;
                            cmd_select_q <= (byte_err != ERR_NONE) ? SEL_ERROR : ok_sel;
                            error_q      <= (byte_err != ERR_NONE);
                            err_code_q   <= byte_err;
                            if (state_q == ST_PAYLOAD) payload_len_q <= len_q;
                        end else if (state_q == ST_HDR && op_q == OP_WRITE && idx_q == IDX_ID) begin
                            state_q <= ST_PAYLOAD;
                            idx_q   <= '0;
                            rem_q   <= rx_data;
                            len_q   <= rx_data;
                        end
                    end else if (tmr_expired) begin
                        state_q      <= ST_RESP;
                        rx_ready_q   <= 1'b0;
                        cmd_valid_q  <= 1'b1;
                        cmd_select_q <= SEL_ERROR;
                        error_q      <= 1'b1;
                        err_code_q   <= ERR_TIMEOUT;
                    end
                end
                ST_RESP: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        rx_ready_q  <= 1'b1;
                        // Format errors leave the rest of the frame on the wire.
                        if (error_q && err_code_q != ERR_TIMEOUT) begin
                            state_q <= ST_FLUSH;
                        end else begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!rx_valid && tmr_expired) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_ready    = rx_ready_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_select  = cmd_select_q;
    assign target_addr = target_q;
    assign output_data = data_q;
    assign payload_len = payload_len_q;
    assign error       = error_q;
    assign error_code  = err_code_q;
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule
